// File: rtl/region_dispatcher.sv
// region_dispatcher
//   Region-side counterpart of the load balancer. Each accepted meta beat goes
//   into the FIFO of the region chosen by lb_ctrl. Each FIFO drives its own
//   AXI4-Stream-style output with first-word fall-through. Per-region
//   {operator id, load} is reported on region_stats_out. An operator id is
//   reprogrammed by a per-region FSM that drains the region before swapping
//   in the new id.
//
// Ports
//   aclk, areset        clock, synchronous active-high reset
//   meta_t*             incoming meta beats (valid/ready/data)
//   lb_ctrl             target region for the current beat
//   reg_t*              per-region output streams; region i at [i*W +: W]
//   pr_*                reprogram request: region and new operator id
//   region_full         FIFO i holds QDEPTH entries
//   region_stats_out    region i at [i*F +: F] = {oid_i, load_i}
//
// Configuration macro
//   STATS_REG_EN        register region_stats_out (one cycle behind live state)
module region_dispatcher #(
    parameter int unsigned HTTP_META_WIDTH   = 8,
    parameter int unsigned OPERATOR_ID_WIDTH = 2,
    parameter int unsigned N_REGIONS         = 4,
    parameter int unsigned QDEPTH            = 4,
    parameter int unsigned PNTR_BITS         = $clog2(QDEPTH)
) (
    input  logic                                               aclk,
    input  logic                                               areset,
    input  logic                                               meta_tvalid,
    output logic                                               meta_tready,
    input  logic [HTTP_META_WIDTH-1:0]                         meta_tdata,
    input  logic [$clog2(N_REGIONS)-1:0]                       lb_ctrl,
    output logic [N_REGIONS-1:0]                               reg_tvalid,
    input  logic [N_REGIONS-1:0]                               reg_tready,
    output logic [N_REGIONS*HTTP_META_WIDTH-1:0]               reg_tdata,
    input  logic                                               pr_valid,
    output logic                                               pr_ready,
    input  logic [$clog2(N_REGIONS)-1:0]                       pr_region,
    input  logic [OPERATOR_ID_WIDTH-1:0]                       pr_oid,
    output logic [N_REGIONS-1:0]                               region_full,
    output logic [N_REGIONS*(OPERATOR_ID_WIDTH+PNTR_BITS)-1:0] region_stats_out
);

    localparam int unsigned SelW  = $clog2(N_REGIONS);
    localparam int unsigned CntW  = PNTR_BITS + 1;
    localparam int unsigned StatW = OPERATOR_ID_WIDTH + PNTR_BITS;
    localparam logic [PNTR_BITS-1:0] LoadMax = '1;

    typedef enum logic [1:0] {StActive, StDrain, StSwap} state_e;

    state_e                       state_q [N_REGIONS];
    state_e                       state_d [N_REGIONS];
    logic [CntW-1:0]              count_q [N_REGIONS];
    logic [CntW-1:0]              count_d [N_REGIONS];
    logic [PNTR_BITS-1:0]         wr_ptr_q [N_REGIONS];
    logic [PNTR_BITS-1:0]         wr_ptr_d [N_REGIONS];
    logic [PNTR_BITS-1:0]         rd_ptr_q [N_REGIONS];
    logic [PNTR_BITS-1:0]         rd_ptr_d [N_REGIONS];
    logic [HTTP_META_WIDTH-1:0]   mem_q [N_REGIONS][QDEPTH];
    logic [HTTP_META_WIDTH-1:0]   mem_d [N_REGIONS][QDEPTH];
    logic [OPERATOR_ID_WIDTH-1:0] oid_q [N_REGIONS];
    logic [OPERATOR_ID_WIDTH-1:0] oid_d [N_REGIONS];
    logic [OPERATOR_ID_WIDTH-1:0] pend_oid_q;
    logic [OPERATOR_ID_WIDTH-1:0] pend_oid_d;

    logic [N_REGIONS-1:0]         meta_sel;
    logic [N_REGIONS-1:0]         pr_sel;
    logic [N_REGIONS-1:0]         full;
    logic [N_REGIONS-1:0]         enq_allowed;
    logic [N_REGIONS-1:0]         enq;
    logic [N_REGIONS-1:0]         deq;
    logic                         pr_fire;
    logic [N_REGIONS*StatW-1:0]   stats_live;

    // Decode selectors by equality so an out-of-range index selects nothing.
    always_comb begin
        meta_sel = '0;
        pr_sel   = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            if (lb_ctrl == SelW'(i)) meta_sel[i] = 1'b1;
            if (pr_region == SelW'(i)) pr_sel[i] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < N_REGIONS; i++) begin
            full[i] = (count_q[i] == CntW'(QDEPTH));
        end
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < N_REGIONS; i++) begin
                state_q[i] <= StActive;
                oid_q[i]   <= OPERATOR_ID_WIDTH'(i);
            end
            pend_oid_q <= '0;
        end else begin
            for (int i = 0; i < N_REGIONS; i++) begin
                state_q[i] <= state_d[i];
                oid_q[i]   <= oid_d[i];
            end
            pend_oid_q <= pend_oid_d;
        end
    end

    always_comb begin
        pend_oid_d = pr_fire ? pr_oid : pend_oid_q;
        for (int i = 0; i < N_REGIONS; i++) begin
            state_d[i] = state_q[i];
            oid_d[i]   = oid_q[i];
            unique case (state_q[i])
                StActive: if (pr_fire && pr_sel[i]) state_d[i] = StDrain;
                // Checked on the registered count so an empty region still
                // spends one cycle here.
                StDrain:  if (count_q[i] == '0) state_d[i] = StSwap;
                StSwap: begin
                    oid_d[i]   = pend_oid_q;
                    state_d[i] = StActive;
                end
                default:  state_d[i] = StActive;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < N_REGIONS; i++) begin
            enq_allowed[i] = (state_q[i] == StActive);
        end
        pr_ready = &enq_allowed;
    end

    // ------------------------------------------------------------ handshakes
    assign pr_fire     = pr_valid & pr_ready;
    // No bypass: a full FIFO refuses even when it dequeues this cycle.
    assign meta_tready = ~areset & |(meta_sel & enq_allowed & ~full);
    assign enq         = meta_sel & {N_REGIONS{meta_tvalid & meta_tready}};
    assign deq         = reg_tvalid & reg_tready;

    // --------------------------------------------------------------- FIFOs
    always_comb begin
        for (int i = 0; i < N_REGIONS; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            count_d[i]  = count_q[i];
            for (int j = 0; j < QDEPTH; j++) begin
                mem_d[i][j] = mem_q[i][j];
            end
            if (enq[i]) begin
                mem_d[i][wr_ptr_q[i]] = meta_tdata;
                wr_ptr_d[i]           = wr_ptr_q[i] + 1'b1;
            end
            if (deq[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
            end
            unique case ({enq[i], deq[i]})
                2'b10:   count_d[i] = count_q[i] + 1'b1;
                2'b01:   count_d[i] = count_q[i] - 1'b1;
                default: count_d[i] = count_q[i];
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < N_REGIONS; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_REGIONS; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                count_q[i]  <= count_d[i];
            end
        end
    end

    // Storage needs no reset: contents are only visible while count is non-zero.
    always_ff @(posedge aclk) begin
        for (int i = 0; i < N_REGIONS; i++) begin
            for (int j = 0; j < QDEPTH; j++) begin
                mem_q[i][j] <= mem_d[i][j];
            end
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        for (int i = 0; i < N_REGIONS; i++) begin
            reg_tvalid[i]                                   = (count_q[i] != '0);
            reg_tdata[i*HTTP_META_WIDTH +: HTTP_META_WIDTH] = mem_q[i][rd_ptr_q[i]];
            region_full[i]                                  = full[i];
        end
    end

    // Load saturates; a full FIFO is flagged separately on region_full.
    always_comb begin
        for (int i = 0; i < N_REGIONS; i++) begin
            if (count_q[i] > {1'b0, LoadMax}) begin
                stats_live[i*StatW +: StatW] = {oid_q[i], LoadMax};
            end else begin
                stats_live[i*StatW +: StatW] = {oid_q[i], count_q[i][PNTR_BITS-1:0]};
            end
        end
    end

`ifdef STATS_REG_EN
    logic [N_REGIONS*StatW-1:0] stats_q;
    logic [N_REGIONS*StatW-1:0] stats_d;

    assign stats_d = stats_live;

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < N_REGIONS; i++) begin
                stats_q[i*StatW +: StatW] <= {OPERATOR_ID_WIDTH'(i), {PNTR_BITS{1'b0}}};
            end
        end else begin
            stats_q <= stats_d;
        end
    end

    assign region_stats_out = stats_q;
`else
    assign region_stats_out = stats_live;
`endif

endmodule

// File: tb/tb_region_dispatcher.sv
module tb_region_dispatcher;

    localparam int W  = 8;
    localparam int OW = 2;
    localparam int N  = 4;
    localparam int QD = 4;
    localparam int PB = 2;

    logic             aclk = 1'b0;
    logic             areset;
    logic             meta_tvalid;
    logic             meta_tready;
    logic [W-1:0]     meta_tdata;
    logic [1:0]       lb_ctrl;
    logic [N-1:0]     reg_tvalid;
    logic [N-1:0]     reg_tready;
    logic [N*W-1:0]   reg_tdata;
    logic             pr_valid;
    logic             pr_ready;
    logic [1:0]       pr_region;
    logic [OW-1:0]    pr_oid;
    logic [N-1:0]     region_full;
    logic [N*(OW+PB)-1:0] region_stats_out;

    always #5 aclk = ~aclk;

    region_dispatcher #(
        .HTTP_META_WIDTH   (W),
        .OPERATOR_ID_WIDTH (OW),
        .N_REGIONS         (N),
        .QDEPTH            (QD),
        .PNTR_BITS         (PB)
    ) dut (
        .aclk             (aclk),
        .areset           (areset),
        .meta_tvalid      (meta_tvalid),
        .meta_tready      (meta_tready),
        .meta_tdata       (meta_tdata),
        .lb_ctrl          (lb_ctrl),
        .reg_tvalid       (reg_tvalid),
        .reg_tready       (reg_tready),
        .reg_tdata        (reg_tdata),
        .pr_valid         (pr_valid),
        .pr_ready         (pr_ready),
        .pr_region        (pr_region),
        .pr_oid           (pr_oid),
        .region_full      (region_full),
        .region_stats_out (region_stats_out)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard / reference model
    logic [W-1:0]  mq [N][$];
    int            mstate [N];   // 0 active, 1 drain, 2 swap
    logic [OW-1:0] moid [N];
    logic [OW-1:0] mpend;
    logic [15:0]   prev_stats;

    function automatic logic [15:0] model_stats();
        logic [15:0] s;
        for (int i = 0; i < N; i++) begin
            s[i*4 +: 4] = {moid[i], (mq[i].size() > 3) ? 2'd3 : 2'(mq[i].size())};
        end
        return s;
    endfunction

    always @(negedge aclk) begin
        logic        exp_rdy;
        logic        exp_pr_rdy;
        logic [3:0]  exp_valid;
        logic [3:0]  exp_full;
        logic [15:0] cur;
        if (areset) begin
            check("rst_meta_tready", {31'd0, meta_tready}, 32'd0);
            for (int i = 0; i < N; i++) begin
                mq[i].delete();
                mstate[i] = 0;
                moid[i]   = OW'(i);
            end
            prev_stats = model_stats();
        end else begin
            cur = model_stats();
`ifdef STATS_REG_EN
            check("stats", {16'd0, region_stats_out}, {16'd0, prev_stats});
`else
            check("stats", {16'd0, region_stats_out}, {16'd0, cur});
`endif
            prev_stats = cur;
            exp_pr_rdy = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (mstate[i] != 0) exp_pr_rdy = 1'b0;
                exp_valid[i] = (mq[i].size() != 0);
                exp_full[i]  = (mq[i].size() == QD);
                if (exp_valid[i]) begin
                    check($sformatf("tdata%0d", i), {24'd0, reg_tdata[i*W +: W]},
                          {24'd0, mq[i][0]});
                end
            end
            check("reg_tvalid", {28'd0, reg_tvalid}, {28'd0, exp_valid});
            check("region_full", {28'd0, region_full}, {28'd0, exp_full});
            check("pr_ready", {31'd0, pr_ready}, {31'd0, exp_pr_rdy});
            exp_rdy = (mstate[lb_ctrl] == 0) && (mq[lb_ctrl].size() < QD);
            if (meta_tvalid) check("meta_tready", {31'd0, meta_tready}, {31'd0, exp_rdy});
            for (int i = 0; i < N; i++) begin
                if (mstate[i] == 1 && mq[i].size() == 0) begin
                    mstate[i] = 2;
                end else if (mstate[i] == 2) begin
                    moid[i]   = mpend;
                    mstate[i] = 0;
                end
            end
            if (pr_valid && exp_pr_rdy) begin
                mstate[pr_region] = 1;
                mpend             = pr_oid;
            end
            for (int i = 0; i < N; i++) begin
                if (exp_valid[i] && reg_tready[i]) void'(mq[i].pop_front());
            end
            if (meta_tvalid && exp_rdy) mq[lb_ctrl].push_back(meta_tdata);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    // Holds the beat until accepted; leaves meta_tvalid high for back-to-back use.
    task automatic send(input logic [1:0] r, input logic [W-1:0] d);
        logic ok;
        ok          = 1'b0;
        meta_tvalid = 1'b1;
        lb_ctrl     = r;
        meta_tdata  = d;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge aclk);
            ok = meta_tready;
        end
        check("send_accepted", {31'd0, ok}, 32'd1);
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        areset      = 1'b1;
        meta_tvalid = 1'b0;
        meta_tdata  = '0;
        lb_ctrl     = '0;
        reg_tready  = '0;
        pr_valid    = 1'b0;
        pr_region   = '0;
        pr_oid      = '0;
        cycles(2);
        areset = 1'b0;

        // 1: single beat to region 2
        send(2'd2, 8'hAA);
        meta_tvalid = 1'b0;
        @(negedge aclk);
        check("t1_valid", {28'd0, reg_tvalid}, 32'h4);
        check("t1_data", {24'd0, reg_tdata[23:16]}, 32'hAA);
`ifdef STATS_REG_EN
        @(negedge aclk);
`endif
        check("t1_stats2", {28'd0, region_stats_out[11:8]}, 32'h9);
        @(posedge aclk); #1;
        reg_tready = 4'hF;
        cycles(2);
        reg_tready = '0;

        // 2: fill region 1, fifth beat stalls until one dequeue
        send(2'd1, 8'h01);
        send(2'd1, 8'h02);
        send(2'd1, 8'h03);
        send(2'd1, 8'h04);
        meta_tvalid = 1'b1;
        lb_ctrl     = 2'd1;
        meta_tdata  = 8'h05;
        @(negedge aclk);
        check("t2_full", {31'd0, region_full[1]}, 32'd1);
        check("t2_load1", {30'd0, region_stats_out[5:4]}, 32'd3);
        check("t2_stall", {31'd0, meta_tready}, 32'd0);
        cycles(3);
        reg_tready[1] = 1'b1;
        send(2'd1, 8'h05);
        meta_tvalid = 1'b0;
        cycles(6);
        reg_tready = '0;

        // 3: full region 0 refuses a beat even while dequeuing
        send(2'd0, 8'h11);
        send(2'd0, 8'h22);
        send(2'd0, 8'h33);
        send(2'd0, 8'h44);
        meta_tvalid   = 1'b1;
        lb_ctrl       = 2'd0;
        meta_tdata    = 8'h55;
        reg_tready[0] = 1'b1;
        @(negedge aclk);
        check("t3_refuse", {31'd0, meta_tready}, 32'd0);
        @(posedge aclk); #1;
        @(negedge aclk);
        check("t3_accept", {31'd0, meta_tready}, 32'd1);
        @(posedge aclk); #1;
        meta_tvalid = 1'b0;
        cycles(6);
        reg_tready = '0;

        // 4: reprogram region 3 while it holds two beats
        send(2'd3, 8'hC1);
        send(2'd3, 8'hC2);
        meta_tvalid = 1'b0;
        pr_valid    = 1'b1;
        pr_region   = 2'd3;
        pr_oid      = 2'd1;
        @(negedge aclk);
        check("t4_pr_ready", {31'd0, pr_ready}, 32'd1);
        @(posedge aclk); #1;
        pr_valid = 1'b0;
        @(negedge aclk);
        check("t4_pr_busy", {31'd0, pr_ready}, 32'd0);
        @(posedge aclk); #1;
        meta_tvalid = 1'b1;
        lb_ctrl     = 2'd3;
        meta_tdata  = 8'hC3;
        @(negedge aclk);
        check("t4_blocked", {31'd0, meta_tready}, 32'd0);
        @(posedge aclk); #1;
        reg_tready[3] = 1'b1;
        cycles(8);
        meta_tvalid = 1'b0;
        @(negedge aclk);
        check("t4_oid3", {30'd0, region_stats_out[15:14]}, 32'd1);
        check("t4_pr_back", {31'd0, pr_ready}, 32'd1);
        @(posedge aclk); #1;
        reg_tready = '0;
        cycles(2);

        // 5: reset in the middle of a drain
        send(2'd3, 8'hD1);
        send(2'd3, 8'hD2);
        meta_tvalid = 1'b0;
        pr_valid    = 1'b1;
        pr_region   = 2'd3;
        pr_oid      = 2'd0;
        cycles(1);
        pr_valid = 1'b0;
        cycles(2);
        areset = 1'b1;
        cycles(1);
        areset = 1'b0;
        @(negedge aclk);
        check("t5_oid3", {30'd0, region_stats_out[15:14]}, 32'd3);
        check("t5_valid", {28'd0, reg_tvalid}, 32'd0);
        check("t5_pr_ready", {31'd0, pr_ready}, 32'd1);
        @(posedge aclk); #1;

        // 6: back-to-back beats round-robin across regions
        reg_tready = 4'hF;
        send(2'd0, 8'hA0);
        send(2'd1, 8'hA1);
        send(2'd2, 8'hA2);
        send(2'd3, 8'hA3);
        meta_tvalid = 1'b0;
        @(negedge aclk);
        check("t6_valid3", {28'd0, reg_tvalid}, 32'h8);
        @(posedge aclk); #1;
        cycles(3);
        @(negedge aclk);
        check("end_empty", {28'd0, reg_tvalid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
